// File: rtl/alu_pkg.sv
// alu_pkg: shared micro-op encoding, RFLAGS bit indices and Jcc condition evaluation
package alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_CMP, OP_AND, OP_OR, OP_XOR, OP_TEST, OP_MOV,
    OP_MUL, OP_IMUL, OP_JMP, OP_JCC
  } alu_op_t;
  localparam int RF_CF = 0;
  localparam int RF_PF = 2;
  localparam int RF_ZF = 6;
  localparam int RF_SF = 7;
  localparam int RF_OF = 11;
  function automatic logic cond_true(input logic [3:0] cond, input logic [63:0] flags);
    logic t;
    case (cond[3:1])
      3'd0: t = flags[RF_OF];
      3'd1: t = flags[RF_CF];
      3'd2: t = flags[RF_ZF];
      3'd3: t = flags[RF_CF] | flags[RF_ZF];
      3'd4: t = flags[RF_SF];
      3'd5: t = flags[RF_PF];
      3'd6: t = flags[RF_SF] ^ flags[RF_OF];
      default: t = flags[RF_ZF] | (flags[RF_SF] ^ flags[RF_OF]);
    endcase
    return t ^ cond[0];
  endfunction
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: multi-cycle multiplier that holds its product until the consumer acknowledges
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int MUL_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               kill,
  input  logic               ack,
  input  logic               signed_mul,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(MUL_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic sgn;
  logic [WIDTH-1:0] ra, rb;
  logic [2*WIDTH-1:0] sa, sb;
  // operand latch and countdown; the count parks at zero until the result is taken
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0;
      cnt <= '0;
      sgn <= 1'b0;
      ra <= '0;
      rb <= '0;
    end else if (kill) begin
      busy <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= CW'(MUL_CYCLES - 1);
      ra <= a;
      rb <= b;
      sgn <= signed_mul;
    end else if (busy) begin
      if (cnt != '0) cnt <= cnt - CW'(1);
      else if (ack) busy <= 1'b0;
    end
  end
  assign done = busy && cnt == '0;
  assign sa = {{WIDTH{sgn & ra[WIDTH-1]}}, ra};
  assign sb = {{WIDTH{sgn & rb[WIDTH-1]}}, rb};
  assign product = sa * sb;
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: integer execute stage with handshakes, RFLAGS, iterative multiply and branch resolve
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int MUL_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  alu_op_t            in_op,
  input  logic [3:0]         in_cond,
  input  logic [WIDTH-1:0]   oprd1,
  input  logic [WIDTH-1:0]   oprd2,
  input  logic [63:0]        next_rip,
  input  logic [63:0]        flags_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic [63:0]        rflags,
  output logic               flags_we,
  output logic               branch,
  output logic               branch_taken,
  output logic [63:0]        branch_rip
);
  typedef enum logic {IDLE, MUL_BUSY} state_t;
  state_t state;
  logic can_load, accept, is_mul, mul_busy, mul_done, m_signed, ovf;
  logic cf, of, a_we, a_br, a_tk;
  logic [63:0] m_flags, m_rip, disp, a_flags, a_rip, mul_flags;
  logic [WIDTH:0] sum, dif;
  logic [WIDTH-1:0] r, lo, m_lo, m_hi, ext;
  logic [2*WIDTH-1:0] product;
  function automatic logic [63:0] set_flags(input logic [63:0] f, input logic [WIDTH-1:0] v,
                                            input logic c, input logic o);
    logic [63:0] n;
    n = f;
    n[RF_CF] = c;
    n[RF_PF] = ~^v[7:0];
    n[RF_ZF] = v == '0;
    n[RF_SF] = v[WIDTH-1];
    n[RF_OF] = o;
    return n;
  endfunction
  assign can_load = !out_valid || out_ready;
  assign in_ready = state == IDLE && !mul_busy && can_load && !flush;
  assign accept = in_valid && in_ready;
  assign is_mul = in_op == OP_MUL || in_op == OP_IMUL;
  assign disp = 64'($signed(oprd2));
  assign m_lo = product[WIDTH-1:0];
  assign m_hi = product[2*WIDTH-1:WIDTH];
  assign ext = m_signed ? {WIDTH{m_lo[WIDTH-1]}} : '0;
  assign ovf = m_hi != ext;
  assign mul_flags = set_flags(m_flags, m_lo, ovf, ovf);
  alu_mul_iter #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES)) u_mul (
    .clk(clk), .reset_n(reset_n), .start(accept && is_mul), .kill(flush), .ack(can_load),
    .signed_mul(in_op == OP_IMUL), .a(oprd1), .b(oprd2),
    .busy(mul_busy), .done(mul_done), .product(product)
  );
  // single-cycle ALU, flag generation and branch resolution for the presented micro-op
  always_comb begin
    sum = {1'b0, oprd1} + {1'b0, oprd2};
    dif = {1'b0, oprd1} - {1'b0, oprd2};
    r = '0;
    lo = '0;
    cf = 1'b0;
    of = 1'b0;
    a_we = 1'b1;
    a_br = 1'b0;
    a_tk = 1'b0;
    case (in_op)
      OP_ADD: begin
        r = sum[WIDTH-1:0];
        lo = r;
        cf = sum[WIDTH];
        of = (oprd1[WIDTH-1] == oprd2[WIDTH-1]) && (r[WIDTH-1] != oprd1[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        r = dif[WIDTH-1:0];
        lo = in_op == OP_CMP ? oprd1 : r;
        cf = dif[WIDTH];
        of = (oprd1[WIDTH-1] != oprd2[WIDTH-1]) && (r[WIDTH-1] != oprd1[WIDTH-1]);
      end
      OP_AND, OP_TEST: begin
        r = oprd1 & oprd2;
        lo = in_op == OP_TEST ? oprd1 : r;
      end
      OP_OR: begin
        r = oprd1 | oprd2;
        lo = r;
      end
      OP_XOR: begin
        r = oprd1 ^ oprd2;
        lo = r;
      end
      OP_MOV: begin
        lo = oprd2;
        a_we = 1'b0;
      end
      OP_JMP: begin
        a_we = 1'b0;
        a_br = 1'b1;
        a_tk = 1'b1;
      end
      OP_JCC: begin
        a_we = 1'b0;
        a_br = 1'b1;
        a_tk = cond_true(in_cond, flags_in);
      end
      default: a_we = 1'b0;
    endcase
    a_flags = a_we ? set_flags(flags_in, r, cf, of) : flags_in;
    a_rip = a_tk ? next_rip + disp : next_rip;
  end
  // handshake FSM and output register; flush overrides every other event
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      out_valid <= 1'b0;
      result <= '0;
      rflags <= '0;
      flags_we <= 1'b0;
      branch <= 1'b0;
      branch_taken <= 1'b0;
      branch_rip <= '0;
      m_signed <= 1'b0;
      m_flags <= '0;
      m_rip <= '0;
    end else begin
      if (out_ready || flush) out_valid <= 1'b0;
      if (flush) state <= IDLE;
      else if (state == MUL_BUSY && mul_done && can_load) begin
        state <= IDLE;
        out_valid <= 1'b1;
        result <= product;
        rflags <= mul_flags;
        flags_we <= 1'b1;
        branch <= 1'b0;
        branch_taken <= 1'b0;
        branch_rip <= m_rip;
      end else if (accept && is_mul) begin
        state <= MUL_BUSY;
        m_signed <= in_op == OP_IMUL;
        m_flags <= flags_in;
        m_rip <= next_rip;
      end else if (accept) begin
        out_valid <= 1'b1;
        result <= {{WIDTH{1'b0}}, lo};
        rflags <= a_flags;
        flags_we <= a_we;
        branch <= a_br;
        branch_taken <= a_tk;
        branch_rip <= a_rip;
      end
    end
  end
  // micro-ops outside the defined set are still retired but flagged in simulation
  always_ff @(posedge clk) begin
    if (reset_n && accept) err_illegal_op: assert (in_op <= OP_JCC) else $error("illegal alu_op_t %0d", in_op);
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and randomized checks against a behavioural execute-stage model
module tb_alu_exec_unit;
  import alu_pkg::*;
  typedef struct packed {
    logic [127:0] res;
    logic [63:0]  fl;
    logic         we, br, tk;
    logic [63:0]  rip;
  } exp_t;
  logic clk = 1'b0, reset_n, flush, in_valid, out_ready;
  alu_op_t in_op;
  logic [3:0] in_cond;
  logic [63:0] oprd1, oprd2, next_rip, flags_in;
  logic in_ready, out_valid, flags_we, branch, branch_taken;
  logic [127:0] result;
  logic [63:0] rflags, branch_rip;
  int n_chk = 0, n_fail = 0;
  bit rand_en = 0, held = 0;
  exp_t q[$];
  exp_t me, snap;
  alu_exec_unit #(.WIDTH(64), .MUL_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_cond(in_cond), .oprd1(oprd1), .oprd2(oprd2), .next_rip(next_rip),
    .flags_in(flags_in), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .rflags(rflags), .flags_we(flags_we), .branch(branch), .branch_taken(branch_taken),
    .branch_rip(branch_rip)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic xcond(input logic [3:0] c, input logic [63:0] f);
    logic cf, pf, zf, sf, of;
    cf = f[0]; pf = f[2]; zf = f[6]; sf = f[7]; of = f[11];
    case (c)
      4'h0: return of;            4'h1: return !of;
      4'h2: return cf;            4'h3: return !cf;
      4'h4: return zf;            4'h5: return !zf;
      4'h6: return cf || zf;      4'h7: return !cf && !zf;
      4'h8: return sf;            4'h9: return !sf;
      4'hA: return pf;            4'hB: return !pf;
      4'hC: return sf != of;      4'hD: return sf == of;
      4'hE: return zf || sf != of;
      default: return !zf && sf == of;
    endcase
  endfunction
  function automatic exp_t model(input alu_op_t op, input logic [3:0] c, input logic [63:0] a,
                                 input logic [63:0] b, input logic [63:0] rip, input logic [63:0] fin);
    exp_t e;
    logic [63:0] r;
    logic [127:0] p;
    logic signed [65:0] s;
    logic cf, of, ar;
    e = '0; e.fl = fin; e.rip = rip; r = '0; cf = 0; of = 0; ar = 1;
    case (op)
      OP_ADD: begin
        r = a + b; cf = r < a;
        s = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
        of = s != $signed({{2{r[63]}}, r}); e.res = {64'd0, r};
      end
      OP_SUB, OP_CMP: begin
        r = a - b; cf = a < b;
        s = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
        of = s != $signed({{2{r[63]}}, r}); e.res = {64'd0, op == OP_CMP ? a : r};
      end
      OP_AND: begin r = a & b; e.res = {64'd0, r}; end
      OP_TEST: begin r = a & b; e.res = {64'd0, a}; end
      OP_OR: begin r = a | b; e.res = {64'd0, r}; end
      OP_XOR: begin r = a ^ b; e.res = {64'd0, r}; end
      OP_MUL: begin
        p = {64'd0, a} * {64'd0, b}; r = p[63:0]; cf = p[127:64] != 0; of = cf; e.res = p;
      end
      OP_IMUL: begin
        p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); r = p[63:0];
        cf = p != {{64{p[63]}}, p[63:0]}; of = cf; e.res = p;
      end
      OP_MOV: begin ar = 0; e.res = {64'd0, b}; end
      OP_JMP: begin ar = 0; e.br = 1; e.tk = 1; end
      default: begin ar = 0; e.br = 1; e.tk = xcond(c, fin); end
    endcase
    if (e.tk) e.rip = rip + b;
    if (ar) begin
      e.we = 1;
      e.fl[0] = cf;
      e.fl[2] = $countones(r[7:0]) % 2 == 0;
      e.fl[6] = r == 0;
      e.fl[7] = r[63];
      e.fl[11] = of;
    end
    return e;
  endfunction
  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      held = 0;
    end else begin
      if (held) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_res", result, snap.res);
        chk("hold_flags", rflags, snap.fl);
        chk("hold_bits", {flags_we, branch, branch_taken}, {snap.we, snap.br, snap.tk});
        chk("hold_rip", branch_rip, snap.rip);
      end
      chk("spurious_valid", out_valid && q.size() == 0, 0);
      if (out_valid && out_ready && q.size() > 0) begin
        me = q.pop_front();
        chk("res", result, me.res);
        chk("rflags", rflags, me.fl);
        chk("flags_we", flags_we, me.we);
        chk("branch", branch, me.br);
        chk("taken", branch_taken, me.tk);
        chk("branch_rip", branch_rip, me.rip);
      end
      held = out_valid && !out_ready && !flush;
      snap = {result, rflags, flags_we, branch, branch_taken, branch_rip};
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(model(in_op, in_cond, oprd1, oprd2, next_rip, flags_in));
    end
  end
  always @(posedge clk) begin
    #1;
    if (rand_en) begin
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 39) == 0;
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input alu_op_t op, input logic [3:0] c, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] rip, input logic [63:0] fin);
    int n;
    in_valid = 1; in_op = op; in_cond = c; oprd1 = a; oprd2 = b; next_rip = rip; flags_in = fin;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) chk("accept_timeout", 0, 1);
    step();
    in_valid = 0;
  endtask
  function automatic logic [63:0] rnd();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    reset_n = 0; flush = 0; in_valid = 0; out_ready = 1; in_op = OP_ADD; in_cond = 0;
    oprd1 = 0; oprd2 = 0; next_rip = 0; flags_in = 0;
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_res", result, 0);
    chk("rst_flags", rflags, 0);
    chk("rst_bits", {flags_we, branch, branch_taken}, 0);
    chk("rst_rip", branch_rip, 0);
    step();
    reset_n = 1;
    step();
    issue(OP_ADD, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0);
    @(negedge clk);
    chk("add_valid", out_valid, 1);
    chk("add_res", result, 0);
    chk("add_flags", rflags, 64'h45);
    chk("add_we", flags_we, 1);
    step();
    issue(OP_SUB, 0, 64'h8000_0000_0000_0000, 64'd1, 0, 0);
    @(negedge clk);
    chk("sub_res", result, 128'h7FFF_FFFF_FFFF_FFFF);
    chk("sub_flags", rflags, 64'h804);
    step();
    issue(OP_IMUL, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("imul_busy_ready", in_ready, 0);
      chk("imul_busy_valid", out_valid, 0);
    end
    @(negedge clk);
    chk("imul_valid", out_valid, 1);
    chk("imul_res", result, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE);
    chk("imul_flags", rflags, 64'h80);
    step();
    issue(OP_ADD, 0, 64'd1, 64'd2, 0, 0);
    out_ready = 0;
    in_valid = 1; in_op = OP_ADD; oprd1 = 64'd5; oprd2 = 64'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_res", result, 3);
      chk("stall_ready", in_ready, 0);
    end
    step();
    out_ready = 1;
    @(negedge clk);
    chk("unstall_ready", in_ready, 1);
    chk("unstall_res", result, 3);
    step();
    in_valid = 0;
    @(negedge clk);
    chk("b2b_valid", out_valid, 1);
    chk("b2b_res", result, 10);
    step();
    issue(OP_JCC, 4'd4, 0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h1000, 64'h40);
    @(negedge clk);
    chk("jcc_t_bits", {branch, branch_taken, flags_we}, 3'b110);
    chk("jcc_t_rip", branch_rip, 64'h0FF0);
    chk("jcc_t_res", result, 0);
    step();
    issue(OP_JCC, 4'd4, 0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h1000, 64'h0);
    @(negedge clk);
    chk("jcc_nt_bits", {branch, branch_taken}, 2'b10);
    chk("jcc_nt_rip", branch_rip, 64'h1000);
    step();
    issue(OP_MUL, 0, 64'd3, 64'd5, 0, 0);
    step();
    flush = 1;
    @(negedge clk);
    chk("flush_ready", in_ready, 0);
    step();
    flush = 0;
    @(negedge clk);
    chk("post_flush_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_flush_valid", out_valid, 0);
    end
    step();
    issue(OP_ADD, 0, 64'd1, 64'd2, 64'h2000, 64'hFFFF);
    @(negedge clk);
    chk("add2_flags", rflags, 64'hF73E);
    chk("add2_rip", branch_rip, 64'h2000);
    step();
    issue(OP_MUL, 0, 64'd3, 64'd5, 0, 0);
    step();
    reset_n = 0;
    #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_res", result, 0);
    chk("mrst_flags", rflags, 0);
    chk("mrst_rip", branch_rip, 0);
    step();
    step();
    reset_n = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("mrst_no_output", out_valid, 0);
    end
    step();
    rand_en = 1;
    for (int i = 0; i < 300; i++)
      issue(alu_op_t'($urandom_range(0, 11)), 4'($urandom_range(0, 15)), rnd(), rnd(),
            {$urandom, $urandom}, {$urandom, $urandom});
    rand_en = 0;
    flush = 0;
    out_ready = 1;
    for (int i = 0; i < 30 && q.size() > 0; i++) @(negedge clk);
    chk("drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
